// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel debouncer: filter mode codes and
// the stability-counter width helper.
package debounce_pkg;

   localparam int MODE_SYMMETRIC = 0;
   localparam int MODE_RISE_ONLY = 1;

   function automatic int cnt_width(input int n);
      if (n <= 2) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: synchroniser chain, stability counter, filtered
// level and registered rise/fall pulses.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int   SYNC_STAGES   = 2,
   parameter int   STABLE_CYCLES = 3,
   parameter int   MODE          = MODE_SYMMETRIC,
   parameter logic RESET_VAL     = 1'b0
) (
   input  logic cclk,
   input  logic clr,
   input  logic ce,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic pulse_next
);

   localparam int            CW       = cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   s_s;
   logic [CW-1:0]          cnt_r;
   logic [CW-1:0]          cnt_nxt_s;
   logic                   dout_r;
   logic                   dout_nxt_s;
   logic                   rise_r;
   logic                   rise_nxt_s;
   logic                   fall_r;
   logic                   fall_nxt_s;

   assign s_s = sync_r[SYNC_STAGES-1];

   // Synchroniser shift chain; runs every edge regardless of ce.
   always_ff @(posedge cclk or posedge clr) begin
      if (clr) begin
         sync_r <= {SYNC_STAGES{RESET_VAL}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      end
   end

   // Next-state decision for counter, filtered level and edge pulses.
   always_comb begin
      cnt_nxt_s  = cnt_r;
      dout_nxt_s = dout_r;
      rise_nxt_s = 1'b0;
      fall_nxt_s = 1'b0;
      if (s_s == dout_r) begin
         cnt_nxt_s = {CW{1'b0}};
      end else if ((MODE == MODE_RISE_ONLY) && !s_s) begin
         // Falling edges bypass the filter entirely in rise-only mode.
         dout_nxt_s = 1'b0;
         cnt_nxt_s  = {CW{1'b0}};
         fall_nxt_s = 1'b1;
      end else if (!ce) begin
         cnt_nxt_s = cnt_r;
      end else if (cnt_r == CNT_LAST) begin
         dout_nxt_s = s_s;
         cnt_nxt_s  = {CW{1'b0}};
         rise_nxt_s = s_s;
         fall_nxt_s = !s_s;
      end else begin
         cnt_nxt_s = cnt_r + CW'(1);
      end
   end

   // Filter state and pulse registers.
   always_ff @(posedge cclk or posedge clr) begin
      if (clr) begin
         cnt_r  <= {CW{1'b0}};
         dout_r <= RESET_VAL;
         rise_r <= 1'b0;
         fall_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_nxt_s;
         dout_r <= dout_nxt_s;
         rise_r <= rise_nxt_s;
         fall_r <= fall_nxt_s;
      end
   end

   assign dout       = dout_r;
   assign rise       = rise_r;
   assign fall       = fall_r;
   assign pulse_next = rise_nxt_s | fall_nxt_s;

endmodule

// File: rtl/debounce_filter_multi.sv
// N-channel debouncer/synchroniser for the PS2 front end; per-channel clean
// levels and edge pulses plus a combined change flag.
module debounce_filter_multi
   import debounce_pkg::*;
#(
   parameter int   CHANNELS      = 1,
   parameter int   SYNC_STAGES   = 2,
   parameter int   STABLE_CYCLES = 3,
   parameter int   MODE          = MODE_SYMMETRIC,
   parameter logic RESET_VAL     = 1'b0
) (
   input  logic                cclk,
   input  logic                clr,
   input  logic                ce,
   input  logic [CHANNELS-1:0] din,
   output logic [CHANNELS-1:0] dout,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                any_change
);

   logic [CHANNELS-1:0] pulse_next_s;
   logic                any_change_r;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES   (SYNC_STAGES),
         .STABLE_CYCLES (STABLE_CYCLES),
         .MODE          (MODE),
         .RESET_VAL     (RESET_VAL)
      ) u_ch (
         .cclk       (cclk),
         .clr        (clr),
         .ce         (ce),
         .din        (din[g]),
         .dout       (dout[g]),
         .rise       (rise[g]),
         .fall       (fall[g]),
         .pulse_next (pulse_next_s[g])
      );
   end

   // Registered from the channels' next-pulse terms so it lines up with rise/fall.
   always_ff @(posedge cclk or posedge clr) begin
      if (clr) begin
         any_change_r <= 1'b0;
      end else begin
         any_change_r <= |pulse_next_s;
      end
   end

   assign any_change = any_change_r;

endmodule

// File: tb/tb_debounce_filter_multi.sv
// Directed self-checking bench for debounce_filter_multi: defaults with four
// channels, a ce-gated STABLE_CYCLES=4 instance and a rise-only instance.
module tb_debounce_filter_multi;

   logic       cclk = 1'b0;
   logic       clr;

   logic [3:0] d_din, d_dout, d_rise, d_fall;
   logic       d_ce, d_any;
   logic       c_din, c_ce, c_dout, c_rise, c_fall, c_any;
   logic       r_din, r_ce, r_dout, r_rise, r_fall, r_any;

   int checks = 0;
   int fails  = 0;

   always #5 cclk = ~cclk;

   debounce_filter_multi #(
      .CHANNELS(4), .SYNC_STAGES(2), .STABLE_CYCLES(3), .MODE(0), .RESET_VAL(1'b0)
   ) u_def (
      .cclk(cclk), .clr(clr), .ce(d_ce), .din(d_din),
      .dout(d_dout), .rise(d_rise), .fall(d_fall), .any_change(d_any)
   );

   debounce_filter_multi #(
      .CHANNELS(1), .SYNC_STAGES(2), .STABLE_CYCLES(4), .MODE(0), .RESET_VAL(1'b0)
   ) u_ce (
      .cclk(cclk), .clr(clr), .ce(c_ce), .din(c_din),
      .dout(c_dout), .rise(c_rise), .fall(c_fall), .any_change(c_any)
   );

   debounce_filter_multi #(
      .CHANNELS(1), .SYNC_STAGES(2), .STABLE_CYCLES(3), .MODE(1), .RESET_VAL(1'b0)
   ) u_ro (
      .cclk(cclk), .clr(clr), .ce(r_ce), .din(r_din),
      .dout(r_dout), .rise(r_rise), .fall(r_fall), .any_change(r_any)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge cclk);
         #1;
      end
   endtask

   initial begin
      logic [6:0] pat;
      int         nrise;
      int         first;
      int         nany;
      logic [3:0] rise_at5;
      logic [3:0] ch1_rises;
      logic       dout_at11;

      clr   = 1'b1;
      d_din = 4'b0000;
      d_ce  = 1'b1;
      c_din = 1'b0;
      c_ce  = 1'b0;
      r_din = 1'b0;
      r_ce  = 1'b1;

      tick(2);
      chk("reset_dout", d_dout, 4'b0000);
      chk("reset_rise", d_rise, 4'b0000);
      chk("reset_fall", d_fall, 4'b0000);
      chk("reset_any", d_any, 1'b0);
      chk("reset_ce_dout", c_dout, 1'b0);
      chk("reset_ro_dout", r_dout, 1'b0);
      clr = 1'b0;
      tick(1);

      // clean step up and down on channel 0
      d_din = 4'b0001;
      tick(4);
      chk("step_edge4_dout", d_dout, 4'b0000);
      tick(1);
      chk("step_edge5_dout", d_dout, 4'b0001);
      chk("step_edge5_rise", d_rise, 4'b0001);
      chk("step_edge5_fall", d_fall, 4'b0000);
      chk("step_edge5_any", d_any, 1'b1);
      tick(1);
      chk("step_edge6_rise", d_rise, 4'b0000);
      chk("step_edge6_any", d_any, 1'b0);
      chk("step_edge6_dout", d_dout, 4'b0001);
      d_din = 4'b0000;
      tick(4);
      chk("fall_edge4_dout", d_dout, 4'b0001);
      tick(1);
      chk("fall_edge5_fall", d_fall, 4'b0001);
      chk("fall_edge5_dout", d_dout, 4'b0000);
      tick(1);
      chk("fall_edge6_fall", d_fall, 4'b0000);

      // asynchronous reset mid-count
      d_din = 4'b0010;
      tick(5);
      chk("pre_clr_dout", d_dout, 4'b0010);
      d_din = 4'b0011;
      tick(3);
      clr = 1'b1;
      #2;
      chk("async_clr_dout", d_dout, 4'b0000);
      chk("async_clr_rise", d_rise, 4'b0000);
      tick(1);
      clr = 1'b0;
      tick(4);
      chk("post_clr_edge4_dout", d_dout, 4'b0000);
      tick(1);
      chk("post_clr_edge5_dout", d_dout, 4'b0011);
      chk("post_clr_edge5_rise", d_rise, 4'b0011);
      d_din = 4'b0000;
      tick(5);
      chk("post_clr_fall", d_fall, 4'b0011);
      chk("post_clr_fall_dout", d_dout, 4'b0000);
      tick(1);

      // bounce rejection on channel 0: 1,1,0,1,1,1,1 then held high
      pat   = 7'b1111011;
      nrise = 0;
      first = 0;
      for (int k = 1; k <= 12; k++) begin
         d_din[0] = (k <= 7) ? pat[k-1] : 1'b1;
         tick(1);
         if (d_rise[0]) begin
            nrise++;
            if (first == 0) first = k;
         end
      end
      chk("bounce_first_rise_edge", first, 8);
      chk("bounce_rise_count", nrise, 1);
      chk("bounce_dout", d_dout, 4'b0001);
      d_din = 4'b0000;
      tick(6);
      chk("bounce_return_dout", d_dout, 4'b0000);

      // channels 0 and 2 stepped together, channel 1 toggling every edge
      nany      = 0;
      rise_at5  = 4'b0000;
      ch1_rises = 4'b0000;
      for (int k = 1; k <= 10; k++) begin
         d_din = {1'b0, 1'b1, ((k % 2) == 1), 1'b1};
         tick(1);
         if (d_any) nany++;
         if (k == 5) rise_at5 = d_rise;
         ch1_rises = ch1_rises | (d_rise & 4'b0010);
      end
      chk("multi_rise_edge5", rise_at5, 4'b0101);
      chk("multi_any_cycles", nany, 1);
      chk("multi_ch1_no_rise", ch1_rises, 4'b0000);
      chk("multi_dout", d_dout, 4'b0101);

      // ce asserted every third edge, STABLE_CYCLES=4
      c_din     = 1'b1;
      nrise     = 0;
      first     = 0;
      dout_at11 = 1'bx;
      for (int k = 1; k <= 14; k++) begin
         c_ce = ((k % 3) == 0);
         tick(1);
         if (k == 11) dout_at11 = c_dout;
         if (c_rise) begin
            nrise++;
            if (first == 0) first = k;
         end
      end
      chk("ce_dout_edge11", dout_at11, 1'b0);
      chk("ce_first_rise_edge", first, 12);
      chk("ce_rise_count", nrise, 1);
      chk("ce_dout_final", c_dout, 1'b1);

      // rise-only mode
      r_din = 1'b1;
      tick(4);
      chk("ro_rise_edge4_dout", r_dout, 1'b0);
      tick(1);
      chk("ro_rise_edge5_rise", r_rise, 1'b1);
      chk("ro_rise_edge5_dout", r_dout, 1'b1);
      tick(1);
      r_ce  = 1'b0;
      r_din = 1'b0;
      tick(2);
      chk("ro_fall_edge2_dout", r_dout, 1'b1);
      chk("ro_fall_edge2_fall", r_fall, 1'b0);
      tick(1);
      chk("ro_fall_edge3_fall", r_fall, 1'b1);
      chk("ro_fall_edge3_dout", r_dout, 1'b0);
      chk("ro_fall_edge3_any", r_any, 1'b1);
      tick(1);
      chk("ro_fall_edge4_fall", r_fall, 1'b0);
      r_din = 1'b1;
      tick(8);
      chk("ro_rise_needs_ce", r_dout, 1'b0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/debounce_filter_multi.md
Name: debounce_filter_multi

Overview:
- Parametrised N-channel debouncer and synchroniser for the PS2 keyboard front end. Channels include PS2 clock/data lines, pushbuttons and switches.
- Each channel has a configurable synchroniser, a stability counter with clock-enable, and a selectable filter mode.
- Outputs per channel: clean level plus single-cycle rise/fall pulses. Downstream PS2 receiver logic consumes these edges directly.

Parameters:
- CHANNELS, 1, number of independent input channels (>=1).
- SYNC_STAGES, 2, synchroniser flip-flops per channel (>=2).
- STABLE_CYCLES, 3, consecutive enabled cycles an input must hold a new value before dout follows (>=1).
- MODE, 0, 0 = symmetric (both transitions filtered); 1 = rise-only (rising filtered, falling passes after synchroniser only).
- RESET_VAL, 0, reset level of dout, synchroniser stages and internal state (applied to all channels).

Ports:
- cclk  in  1  clock.
- clr  in  1  reset, asynchronous, active-high.
- ce  in  1  count enable; stability counters advance only when high; synchronisers always run.
- din  in  CHANNELS  raw asynchronous inputs.
- dout  out  CHANNELS  debounced levels.
- rise  out  CHANNELS  one-cycle pulse, coincident with dout 0->1.
- fall  out  CHANNELS  one-cycle pulse, coincident with dout 1->0.
- any_change  out  1  OR of all rise and fall bits, same cycle.

Behaviour:
- Reset (clr=1, async): synchroniser stages and dout take RESET_VAL. Counters go to 0. rise, fall and any_change go to 0.
- Reset mid-count discards progress. After release, counting restarts from 0.
- Synchroniser: s = last stage of a SYNC_STAGES-deep shift of din. Delay is SYNC_STAGES edges.
- Counter width is max(1, clog2(STABLE_CYCLES)). Arithmetic is unsigned.
- Counter never exceeds STABLE_CYCLES-1, so no wrap.
- Per channel, each edge, symmetric mode (MODE=0):
  - s == dout: cnt <= 0.
  - s != dout and ce=0: cnt holds.
  - s != dout, ce=1, cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - s != dout, ce=1, cnt == STABLE_CYCLES-1: dout <= s, cnt <= 0, and the matching rise/fall pulse is asserted for that cycle.
- A glitch that makes s equal dout for one edge resets cnt to 0. Counting restarts.
- Latency with ce held at 1: dout changes on edge SYNC_STAGES+STABLE_CYCLES, counting as edge 1 the first edge that samples the new din.
- Defaults (2, 3): dout changes on edge 5.
- STABLE_CYCLES=1: dout changes on edge SYNC_STAGES+1, i.e. the first enabled edge with s != dout.
- Rise-only mode (MODE=1):
  - Rising transitions are handled exactly as in symmetric mode.
  - When s=0 and dout=1, dout <= 0 on that edge regardless of ce, cnt <= 0, and fall asserts.
- rise and fall are registered. They are never asserted together on one channel. They drop on the next edge.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses, and any_change=1 for that single cycle.
- No combinational path from din to any output.

Decomposition:
- Shared package debounce_pkg:
  - MODE_SYMMETRIC=0 and MODE_RISE_ONLY=1.
  - Function for counter width (max(1, clog2(n))).
- Sub-module debounce_channel: one channel containing synchroniser, counter, state, and rise/fall registers.
- Top generates CHANNELS instances and ORs the pulses into any_change.

Test Plan:
- Reset: clr pulsed mid-count with RESET_VAL=0 -> dout=0, rise=fall=0 immediately (asynchronous). A held din=1 then needs a full 5 edges after release before rise.
- Clean step (defaults, ce=1): din 0->1 -> dout=1 and rise=1 on edge 5, rise=0 on edge 6. din 1->0 -> fall on edge 5.
- Bounce rejection: din pattern 1,1,0,1,1,1,1 (one per edge) -> no rise until 5 edges after the last 0->1. Pulse count is exactly 1.
- ce gating (STABLE_CYCLES=4): ce high every 3rd cycle while din=1 -> dout rises after 4 enabled edges following synchroniser delay. Counter holds between enables.
- Rise-only mode (MODE=1): rising edge takes 5 edges. din 1->0 -> fall on edge 3 with ce=0.
- Multi-channel (CHANNELS=4): channels 0 and 2 stepped the same cycle, channel 1 bounced -> rise[0] and rise[2] on the same edge, any_change=1 for one cycle, channel 1 unchanged.
